mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Memory controller that serves the MEM-stage data port and the IF-stage fetch port over one byte-wide synchronous RAM.
- Splits half/word accesses into little-endian byte transfers.
- Sign/zero-extends read data and reports completion with a one-cycle done pulse per port.
- Sits between the pipeline stages and the top-level RAM/IO bus.

Parameters:
- ADDR_WIDTH, 32, width of all address buses (ma_i, if_addr_i, ram_a_o).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- rdy  input  1  global enable; low freezes all state
- mre_i  input  2  data read size: 00 none, 01 byte, 10 half, 11 word
- mrsign_i  input  1  1 = sign-extend read, 0 = zero-extend
- mwe_i  input  2  data write size, same encoding as mre_i
- mwdata_i  input  32  write data; low bytes used
- ma_i  input  ADDR_WIDTH  data byte address
- busy_o  output  1  controller is transferring, new requests not accepted
- data_o  output  32  extended read data; valid when done_o=1
- done_o  output  1  data-port completion pulse, one cycle
- if_re_i  input  1  instruction fetch request (word)
- if_addr_i  input  ADDR_WIDTH  fetch address
- if_data_o  output  32  fetched word; valid when if_done_o=1
- if_done_o  output  1  fetch completion pulse, one cycle
- ram_a_o  output  ADDR_WIDTH  RAM byte address
- ram_dout_o  output  8  RAM write byte
- ram_wr_o  output  1  1 = write this cycle
- ram_din_i  input  8  RAM read byte; valid one cycle after its address

Behaviour:
- Reset values:
  - state IDLE; busy_o, done_o, if_done_o, ram_wr_o = 0.
  - data_o, if_data_o, ram_a_o, ram_dout_o = 0.
  - Reset mid-transfer aborts immediately; no further ram_wr_o.
- rdy=0: every register holds; ram_wr_o forced 0 that cycle.
- Requests are level-held by the requester until its done pulse.
- Acceptance happens only in IDLE. Arbitration order:
  - mwe_i != 00 wins; then mre_i != 00; then if_re_i.
  - Simultaneous data and fetch requests: data served first; fetch stays pending and is accepted in the first IDLE cycle after.
- Byte count N: byte=1, half=2, word=4 (fetch=4). Byte i uses address base+i, little-endian (byte 0 = bits 7:0).
- States:
  - IDLE: latch request, base address, size, sign and write data.
  - WRITE: drive ram_a_o=base+i, ram_dout_o=byte i, ram_wr_o=1 for N consecutive cycles, then DONE.
  - READ: drive ram_a_o=base+i for N cycles. Capture ram_din_i into byte i-1 each following cycle. One extra capture cycle (ram_wr_o=0) for the last byte, then DONE.
  - DONE: one cycle. done_o (data) or if_done_o (fetch) = 1, busy_o=0, data outputs stable. No acceptance this cycle; always returns to IDLE.
- Latency, counted from acceptance cycle 0:
  - Write: done in cycle N+1.
  - Read: done in cycle N+2.
  - Word fetch: done in cycle 6.
- busy_o = 1 from cycle 1 through the last WRITE/READ cycle. It is 0 in IDLE and in DONE.
- Extension:
  - byte: bit 7 replicated if mrsign_i, else zeros.
  - half: bit 15 replicated if mrsign_i, else zeros.
  - word and fetch: unchanged.
- Address arithmetic is ADDR_WIDTH modulo; base+i wraps at 2^ADDR_WIDTH.
- mre_i and mwe_i both nonzero: treated as a write.
- Request inputs changing mid-transfer are ignored; the latched copies are used.

Optional Feature:
- MEMCTRL_ALIGN_CHK_EN defined:
  - Adds output misalign_o (1 bit, reset 0).
  - Data half with ma_i[0]=1, or data word with ma_i[1:0]!=0, goes IDLE->DONE directly with no RAM cycle.
  - In that DONE cycle: done_o=1, misalign_o=1, data_o=0.
  - Fetch with if_addr_i[1:0]!=0 is handled the same way with if_done_o.
- Not defined: no misalign_o port; misaligned accesses proceed bytewise as normal.

Test Plan:
- Data word write 0xDEADBEEF at 0x100 -> ram_wr_o=1 for 4 cycles: (0x100,EF), (0x101,BE), (0x102,AD), (0x103,DE); done_o in cycle 5.
- RAM 0x200..0x203 = 11,22,33,84; word read at 0x200 -> done_o in cycle 6, data_o=0x84332211.
- RAM 0x203 = 0x84: signed byte read -> data_o=0xFFFFFF84; unsigned byte read -> 0x00000084.
- Data read and if_re_i raised in the same cycle -> data done_o first. Fetch accepted in the IDLE after DONE; if_done_o 6 cycles later with the correct word.
- rdy low for 3 cycles mid word-read -> ram_wr_o=0 and state frozen; completion delayed exactly 3 cycles; value correct. rst mid-write -> no ram_wr_o next cycle.
- MEMCTRL_ALIGN_CHK_EN: word read at 0x102 -> done_o and misalign_o in cycle 1, no ram_a_o activity.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller for data and fetch ports; MEMCTRL_ALIGN_CHK_EN adds misalignment trapping
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [1:0]            mre_i,
  input  logic                  mrsign_i,
  input  logic [1:0]            mwe_i,
  input  logic [31:0]           mwdata_i,
  input  logic [ADDR_WIDTH-1:0] ma_i,
  output logic                  busy_o,
  output logic [31:0]           data_o,
  output logic                  done_o,
  input  logic                  if_re_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [31:0]           if_data_o,
  output logic                  if_done_o,
`ifdef MEMCTRL_ALIGN_CHK_EN
  output logic                  misalign_o,
`endif
  output logic [ADDR_WIDTH-1:0] ram_a_o,
  output logic [7:0]            ram_dout_o,
  output logic                  ram_wr_o,
  input  logic [7:0]            ram_din_i
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
  state_t state, state_nxt;
  logic [2:0] cnt, len, acc_n;
  logic [1:0] sz, acc_sz, idx;
  logic [ADDR_WIDTH-1:0] base, acc_a;
  logic [31:0] wdata, rbuf, buf_nxt, ext;
  logic sign, fetch, req_w, req_r, acc, acc_f, acc_mis;
  assign req_w  = |mwe_i;
  assign req_r  = |mre_i;
  assign acc    = state == IDLE && (req_w || req_r || if_re_i);
  assign acc_f  = !(req_w || req_r);
  assign acc_sz = req_w ? mwe_i : req_r ? mre_i : 2'b11;
  assign acc_a  = acc_f ? if_addr_i : ma_i;
  assign acc_n  = acc_sz == 2'b01 ? 3'd1 : acc_sz == 2'b10 ? 3'd2 : 3'd4;
  assign idx    = cnt[1:0] - 2'd1;
`ifdef MEMCTRL_ALIGN_CHK_EN
  logic mis;
  assign acc_mis    = acc_sz == 2'b10 ? acc_a[0] : acc_sz == 2'b11 && acc_a[1:0] != 2'b00;
  assign misalign_o = state == DONE && mis;
  always_ff @(posedge clk) begin
    if (rst) mis <= 1'b0;
    else if (rdy && acc) mis <= acc_mis;
  end
`else
  assign acc_mis = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else if (rdy) state <= state_nxt;
  end
  always_comb begin
    state_nxt  = state == IDLE  ? (acc ? (acc_mis ? DONE : req_w ? WRITE : READ) : IDLE)
               : state == WRITE ? (cnt == len - 3'd1 ? DONE : WRITE)
               : state == READ  ? (cnt == len ? DONE : READ)
               : IDLE;
    busy_o     = state == WRITE || state == READ;
    done_o     = state == DONE && !fetch;
    if_done_o  = state == DONE && fetch;
    ram_wr_o   = state == WRITE && rdy;
    ram_dout_o = state == WRITE ? wdata[{cnt[1:0], 3'b000} +: 8] : 8'h00;
    // While stalled, re-present the previous address so ram_din_i still carries the byte awaiting capture
    ram_a_o    = busy_o ? base + ADDR_WIDTH'(rdy || cnt == 3'd0 ? cnt : cnt - 3'd1) : '0;
    buf_nxt    = rbuf;
    if (state == READ && cnt != 3'd0) buf_nxt[{idx, 3'b000} +: 8] = ram_din_i;
    ext        = sz == 2'b01 ? {{24{sign & buf_nxt[7]}}, buf_nxt[7:0]}
               : sz == 2'b10 ? {{16{sign & buf_nxt[15]}}, buf_nxt[15:0]}
               : buf_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      len       <= '0;
      sz        <= '0;
      base      <= '0;
      wdata     <= '0;
      rbuf      <= '0;
      sign      <= 1'b0;
      fetch     <= 1'b0;
      data_o    <= '0;
      if_data_o <= '0;
    end else if (rdy) begin
      cnt  <= busy_o ? cnt + 3'd1 : 3'd0;
      rbuf <= buf_nxt;
      if (acc) begin
        base  <= acc_a;
        sz    <= acc_sz;
        len   <= acc_n;
        wdata <= mwdata_i;
        sign  <= mrsign_i;
        fetch <= acc_f;
        rbuf  <= '0;
      end
      if (state == READ && cnt == len) begin
        if (fetch) if_data_o <= buf_nxt;
        else data_o <= ext;
      end
      if (acc && acc_mis) begin
        if (acc_f) if_data_o <= '0;
        else data_o <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl with a byte-wide synchronous RAM model
module tb_mem_ctrl;
  logic clk, rst, rdy, mrsign_i, busy_o, done_o, if_re_i, if_done_o, ram_wr_o, load;
  logic [1:0] mre_i, mwe_i;
  logic [31:0] mwdata_i, ma_i, data_o, if_addr_i, if_data_o, ram_a_o;
  logic [7:0] ram_dout_o, ram_din_i;
  logic [7:0] mem [0:1023];
`ifdef MEMCTRL_ALIGN_CHK_EN
  logic misalign_o;
`endif
  int cyc = 0, n_chk = 0, n_fail = 0;
  typedef struct {bit f; bit chk; logic [31:0] d; int c;} exp_t;
  typedef struct {logic [31:0] a; logic [7:0] d;} wr_t;
  exp_t dq[$];
  wr_t wq[$];

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mre_i(mre_i), .mrsign_i(mrsign_i), .mwe_i(mwe_i),
    .mwdata_i(mwdata_i), .ma_i(ma_i), .busy_o(busy_o), .data_o(data_o), .done_o(done_o),
    .if_re_i(if_re_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_done_o(if_done_o),
`ifdef MEMCTRL_ALIGN_CHK_EN
    .misalign_o(misalign_o),
`endif
    .ram_a_o(ram_a_o), .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o), .ram_din_i(ram_din_i)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[512] <= 8'h11; mem[513] <= 8'h22; mem[514] <= 8'h33; mem[515] <= 8'h84;
    end else begin
      if (ram_wr_o) mem[ram_a_o[9:0]] <= ram_dout_o;
      ram_din_i <= mem[ram_a_o[9:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    wr_t w;
    if (done_o || if_done_o) begin
      if (dq.size() == 0) check("unexpected_done", {31'b0, done_o | if_done_o}, 32'd0);
      else begin
        e = dq.pop_front();
        check("done_port", {31'b0, if_done_o}, {31'b0, e.f});
        check("done_cycle", cyc, e.c);
        if (e.chk) check(e.f ? "if_data" : "data", e.f ? if_data_o : data_o, e.d);
      end
    end
    if (ram_wr_o) begin
      if (wq.size() == 0) check("unexpected_write", {31'b0, ram_wr_o}, 32'd0);
      else begin
        w = wq.pop_front();
        check("wr_addr", ram_a_o, w.a);
        check("wr_byte", {24'b0, ram_dout_o}, {24'b0, w.d});
      end
    end
  end

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input int n);
    wr_t w;
    for (int i = 0; i < n; i++) begin
      w.a = a + i;
      w.d = d[8*i +: 8];
      wq.push_back(w);
    end
  endtask

  task automatic push_exp(input bit f, input bit chk, input logic [31:0] d, input int c);
    exp_t e;
    e.f = f; e.chk = chk; e.d = d; e.c = c;
    dq.push_back(e);
  endtask

  task automatic wait_done(input bit f);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = f ? if_done_o : done_o;
    end
    if (!seen) check(f ? "if_done_timeout" : "done_timeout", {31'b0, seen}, 32'd1);
  endtask

  task automatic data_op(input logic [1:0] we, input logic [1:0] re, input logic sgn,
                         input logic [31:0] wd, input logic [31:0] a, input logic [31:0] exp,
                         input bit stall);
    logic [1:0] sz;
    int n, lat;
    @(posedge clk); #1;
    mwe_i = we; mre_i = re; mrsign_i = sgn; mwdata_i = wd; ma_i = a;
    sz = we != 2'b00 ? we : re;
    n = sz == 2'b01 ? 1 : sz == 2'b10 ? 2 : 4;
    if (we != 2'b00) push_wr(a, wd, n);
    lat = (we != 2'b00 ? n + 1 : n + 2) + (stall ? 3 : 0);
    push_exp(0, we == 2'b00, exp, cyc + lat);
    if (stall) begin
      @(posedge clk); @(posedge clk); #1 rdy = 0;
      repeat (3) @(posedge clk);
      #1 rdy = 1;
    end
    wait_done(0);
    @(posedge clk); #1;
    mwe_i = 0; mre_i = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; load = 1; rdy = 1; mre_i = 0; mwe_i = 0; mrsign_i = 0; mwdata_i = 0; ma_i = 0;
    if_re_i = 0; if_addr_i = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0; load = 0;
    check("rst_busy", {31'b0, busy_o}, 0);
    check("rst_done", {31'b0, done_o}, 0);
    check("rst_if_done", {31'b0, if_done_o}, 0);
    check("rst_ram_wr", {31'b0, ram_wr_o}, 0);
    check("rst_data", data_o, 0);
    check("rst_if_data", if_data_o, 0);
    check("rst_ram_a", ram_a_o, 0);
    check("rst_ram_dout", {24'b0, ram_dout_o}, 0);
    data_op(2'b11, 2'b00, 0, 32'hDEADBEEF, 32'h100, 0, 0);
    data_op(2'b00, 2'b11, 0, 0, 32'h200, 32'h84332211, 0);
    data_op(2'b00, 2'b01, 1, 0, 32'h203, 32'hFFFFFF84, 0);
    data_op(2'b00, 2'b01, 0, 0, 32'h203, 32'h00000084, 0);
    data_op(2'b00, 2'b10, 1, 0, 32'h202, 32'hFFFF8433, 0);
    data_op(2'b01, 2'b00, 0, 32'h5A, 32'h300, 0, 0);
    data_op(2'b00, 2'b01, 0, 0, 32'h300, 32'h5A, 0);
    data_op(2'b01, 2'b11, 0, 32'h77, 32'h110, 0, 0);
    data_op(2'b00, 2'b01, 1, 0, 32'h110, 32'h77, 0);
    // data read and fetch raised together
    @(posedge clk); #1;
    mre_i = 2'b10; mrsign_i = 0; ma_i = 32'h200; if_re_i = 1; if_addr_i = 32'h100;
    push_exp(0, 1, 32'h00002211, cyc + 4);
    push_exp(1, 1, 32'hDEADBEEF, cyc + 11);
    wait_done(0);
    @(posedge clk); #1 mre_i = 0;
    wait_done(1);
    @(posedge clk); #1 if_re_i = 0;
    data_op(2'b00, 2'b11, 0, 0, 32'h200, 32'h84332211, 1);
    data_op(2'b10, 2'b00, 0, 32'hBEEF, 32'h120, 0, 1);
    data_op(2'b00, 2'b10, 0, 0, 32'h120, 32'h0000BEEF, 0);
`ifndef MEMCTRL_ALIGN_CHK_EN
    data_op(2'b10, 2'b00, 0, 32'h1234, 32'h301, 0, 0);
    data_op(2'b00, 2'b11, 0, 0, 32'h300, 32'h0012345A, 0);
    data_op(2'b10, 2'b00, 0, 32'hA1B2, 32'hFFFFFFFF, 0, 0);
    data_op(2'b00, 2'b11, 0, 0, 32'hFFFFFFFF, 32'h0000A1B2, 0);
`else
    @(posedge clk); #1;
    mre_i = 2'b11; ma_i = 32'h102;
    push_exp(0, 1, 32'h0, cyc + 1);
    wait_done(0);
    check("misalign", {31'b0, misalign_o}, 1);
    @(posedge clk); #1 mre_i = 0;
`endif
    // reset in the middle of a word write: only the first two bytes land
    @(posedge clk); #1;
    mwe_i = 2'b11; mwdata_i = 32'hCAFEF00D; ma_i = 32'h140;
    push_wr(32'h140, 32'hCAFEF00D, 2);
    @(posedge clk); @(posedge clk); #1;
    rst = 1; mwe_i = 0;
    @(posedge clk); #1 rst = 0;
    check("mid_rst_busy", {31'b0, busy_o}, 0);
    check("mid_rst_wr", {31'b0, ram_wr_o}, 0);
    data_op(2'b00, 2'b01, 0, 0, 32'h141, 32'h000000F0, 0);
    data_op(2'b00, 2'b01, 0, 0, 32'h142, 32'h00000000, 0);
    data_op(2'b00, 2'b01, 0, 0, 32'h100, 32'h000000EF, 0);
    repeat (5) @(posedge clk);
    check("done_q_empty", dq.size(), 0);
    check("wr_q_empty", wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
